clock_monitor: RTL

Measures an incoming slow clock (e.g. the divided clock from the board's clock divider) in system-clock cycles. Produces single-cycle rise/fall strobes, per-period measurements of period and high time, a lock indication once the period is stable, and a sticky loss flag when the slow clock stops. Sits next to the clock divider as its consumer and checker. Downstream logic uses its strobes as clock enables instead of clocking on the divided signal.

---
 rtl/clock_monitor_pkg.sv | 14 +
 rtl/clock_monitor_edge.sv | 51 +++++
 rtl/clock_monitor.sv | 131 +++++++++++++
 3 files changed

// File: rtl/clock_monitor_pkg.sv
// Shared types and default constants for the clock_monitor slice.
package clock_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam int CNT_W_DEF      = 16;
  localparam int LOCK_COUNT_DEF = 4;
  localparam int TIMEOUT_DEF    = 1024;

endpackage

// File: rtl/clock_monitor_edge.sv
// Samples inClock and produces registered one-cycle rise/fall strobes.
// CLOCK_MONITOR_SYNC_EN adds a 2-flop synchronizer in front of the detector.
module clock_monitor_edge (
  input  logic clock,
  input  logic reset,
  input  logic inClock,
  output logic rise,
  output logic fall
);

  logic s_p0;
  logic p_p1;

`ifdef CLOCK_MONITOR_SYNC_EN
  logic meta_sync;

  // synchronizer: inClock may be asynchronous to clock
  always_ff @(posedge clock) begin
    if (!reset) begin
      meta_sync <= 1'b0;
      s_p0      <= 1'b0;
    end else begin
      meta_sync <= inClock;
      s_p0      <= meta_sync;
    end
  end
`else
  // single sampling flop: inClock is derived from clock
  always_ff @(posedge clock) begin
    if (!reset) begin
      s_p0 <= 1'b0;
    end else begin
      s_p0 <= inClock;
    end
  end
`endif

  // previous level and registered strobes
  always_ff @(posedge clock) begin
    if (!reset) begin
      p_p1 <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      p_p1 <= s_p0;
      rise <= s_p0 & ~p_p1;
      fall <= ~s_p0 & p_p1;
    end
  end

endmodule

// File: rtl/clock_monitor.sv
// Measures period/high time of a slow clock, reports lock and sticky loss.
// Optional input synchronizer selected by CLOCK_MONITOR_SYNC_EN.
module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int LOCK_COUNT = LOCK_COUNT_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inClock,
  input  logic             clearLost,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] highTime,
  output logic             periodValid,
  output logic             locked,
  output logic             lost
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [7:0]       LOCK_N  = 8'(LOCK_COUNT);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] hiReg;
  logic [7:0]       matchCnt;
  logic [7:0]       match_nxt;
  logic             haveRef;
  logic             same;
  logic             meas;
  logic             timeout;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  clock_monitor_edge u_edge (
    .clock   (clock),
    .reset   (reset),
    .inClock (inClock),
    .rise    (rise),
    .fall    (fall)
  );

  assign cnt_inc = cnt + CNT_W'(1);
  // the first period after IDLE has no predecessor to compare against
  assign same    = haveRef && (cnt_inc == period);

  always_comb begin
    state_nxt = state;
    match_nxt = matchCnt;
    meas      = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (rise) state_nxt = MEASURE;
      end
      MEASURE: begin
        if (rise) begin
          meas = 1'b1;
          if (same) begin
            match_nxt = matchCnt + 8'd1;
            if (match_nxt == LOCK_N) state_nxt = LOCKED;
          end else begin
            match_nxt = '0;
          end
        end else if (cnt == TO_LAST) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
          match_nxt = '0;
        end
      end
      LOCKED: begin
        if (rise) begin
          meas = 1'b1;
          if (!same) begin
            state_nxt = MEASURE;
            match_nxt = '0;
          end
        end else if (cnt == TO_LAST) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
          match_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        match_nxt = '0;
      end
    endcase
  end

  // measurement stage: aligned with the rise strobe that closes a period
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      hiReg       <= '0;
      matchCnt    <= '0;
      haveRef     <= 1'b0;
      period      <= '0;
      highTime    <= '0;
      periodValid <= 1'b0;
      locked      <= 1'b0;
      lost        <= 1'b0;
    end else begin
      state       <= state_nxt;
      matchCnt    <= match_nxt;
      cnt         <= rise ? '0 : sat_inc(cnt);
      periodValid <= meas;
      locked      <= (state_nxt == LOCKED);
      if (fall) hiReg <= cnt_inc;
      if (meas) begin
        period   <= cnt_inc;
        highTime <= hiReg;
      end
      if (state_nxt == IDLE) haveRef <= 1'b0;
      else if (meas)         haveRef <= 1'b1;
      // a loss in the same cycle as clearLost keeps the flag set
      if (timeout)        lost <= 1'b1;
      else if (clearLost) lost <= 1'b0;
    end
  end

endmodule
